reg_file_scoreboard: RTL and testbench
======================================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter XLEN, default 64, register data width.
REQ-002 Parameter NREG, default 32, number of architectural registers; index width 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 WriteEn  input  1  write-back valid.
REQ-006 WriteReg  input  5  write-back destination index.
REQ-007 WriteData  input  XLEN  write-back data.
REQ-008 RS1_D  input  5  read-port-1 index.
REQ-009 RS2_D  input  5  read-port-2 index.
REQ-010 RD1_D  output  XLEN  read-port-1 data.
REQ-011 RD2_D  output  XLEN  read-port-2 data.
REQ-012 IssueValid  input  1  instruction issued this cycle with a destination.
REQ-013 IssueRd  input  5  destination of the issued instruction.
REQ-014 Flush  input  1  discard all pending-write tracking.
REQ-015 Stall  output  1  a source register awaits write-back.
REQ-016 PendingCount  output  6  number of registers currently marked busy.

Function
REQ-017 Register array of NREG x XLEN; index 0 SHALL always read 0 and never be written.
REQ-018 Write: at posedge, if WriteEn and WriteReg != 0 and not rst, array[WriteReg] <= WriteData.
REQ-019 WriteEn with WriteReg == 0 SHALL be a no-op for both array and scoreboard.
REQ-020 Reads SHALL be combinational, zero latency.
REQ-021 Write-first bypass: if WriteEn and WriteReg != 0 and WriteReg == RSx_D, RDx_D SHALL equal WriteData in the same cycle.
REQ-022 Scoreboard: one busy bit per register; busy[0] SHALL be constantly 0.
REQ-023 At posedge, IssueValid with IssueRd != 0 SHALL set busy[IssueRd].
REQ-024 At posedge, WriteEn with WriteReg != 0 SHALL clear busy[WriteReg].
REQ-025 Simultaneous set and clear of the same index SHALL leave the bit set (new issue wins).
REQ-026 Flush SHALL clear all busy bits at posedge; Flush SHALL override IssueValid in the same cycle; array writes SHALL still occur.
REQ-027 Stall SHALL be combinational: (busy[RS1_D] or busy[RS2_D]), where a source matching a same-cycle valid write (WriteEn, WriteReg != 0) SHALL count as not busy.
REQ-028 Stall for index 0 SHALL be 0.
REQ-029 PendingCount SHALL be a registered population count of busy bits, valid the cycle after the state change; range 0..31.
REQ-030 Issuing an already-busy register SHALL keep it busy and SHALL NOT increment PendingCount.

Reset
REQ-031 While rst is high at posedge: all array entries <= 0, all busy bits <= 0, PendingCount <= 0; WriteEn, IssueValid, and Flush are ignored.
REQ-032 After reset, RD1_D = RD2_D = 0 and Stall = 0 for any indices, unless a same-cycle write bypass applies.
REQ-033 rst asserted mid-operation SHALL discard pending busy state and register contents at that edge.

Verification
REQ-034 Write-then-read: WriteEn=1, WriteReg=5, WriteData=0xDEAD_BEEF with RS1_D=5 -> RD1_D=0xDEAD_BEEF the same cycle (bypass) and on the following cycle from the array.
REQ-035 x0 protection: WriteEn=1, WriteReg=0, WriteData=0xFFFF_FFFF_FFFF_FFFF, then RS1_D=RS2_D=0 -> RD1_D=RD2_D=0; PendingCount unchanged.
REQ-036 Hazard: IssueValid=1, IssueRd=7; next cycle RS2_D=7 -> Stall=1, PendingCount=1; later WriteEn=1, WriteReg=7, WriteData=0x42 -> Stall=0 that cycle, RD2_D=0x42, PendingCount=0 next cycle.
REQ-037 Collision: busy[3]=1, same cycle IssueValid=1, IssueRd=3 and WriteEn=1, WriteReg=3 -> busy[3] stays 1, PendingCount stays 1, array[3] updated.
REQ-038 Flush: issue 2, 4, 6 (PendingCount=3), then Flush=1 with IssueValid=1, IssueRd=9 -> PendingCount=0, Stall=0 for RS1_D=9.
REQ-039 Reset mid-run: array[10]=0x1234, busy[11]=1, assert rst for one cycle -> RD1_D=0 for RS1_D=10, Stall=0 for RS1_D=11, PendingCount=0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Integer register file with a busy-bit scoreboard for in-order issue.
//   Index 0 is hardwired to zero and is never busy. Reads are combinational
//   with a write-first bypass. The scoreboard marks a destination busy on
//   issue and clears it on write-back. A new issue to the same index in the
//   same cycle as its write-back wins. Flush drops all busy bits.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset (array, busy bits, count)
//   WriteEn       write-back valid
//   WriteReg      write-back destination index
//   WriteData     write-back data
//   RS1_D, RS2_D  read-port indices
//   RD1_D, RD2_D  read-port data (bypassed from a same-cycle write)
//   IssueValid    an instruction with a destination issues this cycle
//   IssueRd       destination of the issuing instruction
//   Flush         clear all busy bits
//   Stall         a source register is busy and is not being written now
//   PendingCount  registered number of busy registers
module reg_file_scoreboard #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WriteEn,
    input  logic [4:0]      WriteReg,
    input  logic [XLEN-1:0] WriteData,
    input  logic [4:0]      RS1_D,
    input  logic [4:0]      RS2_D,
    output logic [XLEN-1:0] RD1_D,
    output logic [XLEN-1:0] RD2_D,
    input  logic            IssueValid,
    input  logic [4:0]      IssueRd,
    input  logic            Flush,
    output logic            Stall,
    output logic [5:0]      PendingCount
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            wr_valid;
    logic            issue_set;
    logic            bypass1;
    logic            bypass2;
    logic            src1_busy;
    logic            src2_busy;

    function automatic logic [5:0] popcount(input logic [NREG-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {5'b0, v[i]};
        end
        return cnt;
    endfunction

    // A write to x0 is a no-op everywhere, including the scoreboard.
    assign wr_valid  = WriteEn && (WriteReg != 5'd0);
    assign issue_set = IssueValid && (IssueRd != 5'd0);

    // Clear first, then set, so a same-index issue beats its own write-back.
    // Flush then overrides everything, including the new issue.
    always_comb begin
        busy_nxt = busy;
        if (wr_valid) begin
            busy_nxt[WriteReg] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[IssueRd] = 1'b1;
        end
        if (Flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy         <= '0;
            PendingCount <= '0;
        end else begin
            if (wr_valid) begin
                regs[WriteReg] <= WriteData;
            end
            busy         <= busy_nxt;
            // Counting the next state makes the count line up with busy.
            PendingCount <= popcount(busy_nxt);
        end
    end

    assign bypass1 = wr_valid && (WriteReg == RS1_D);
    assign bypass2 = wr_valid && (WriteReg == RS2_D);

    always_comb begin
        RD1_D = '0;
        RD2_D = '0;
        if (RS1_D != 5'd0) begin
            RD1_D = bypass1 ? WriteData : regs[RS1_D];
        end
        if (RS2_D != 5'd0) begin
            RD2_D = bypass2 ? WriteData : regs[RS2_D];
        end
    end

    // A source being written back this cycle is already satisfied.
    assign src1_busy = (RS1_D != 5'd0) && busy[RS1_D] && !bypass1;
    assign src2_busy = (RS2_D != 5'd0) && busy[RS2_D] && !bypass2;
    assign Stall     = src1_busy || src2_busy;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Testbench for reg_file_scoreboard: directed scenarios followed by random
// traffic, all checked against a behavioural array/busy-set model.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst;
    logic        WriteEn;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic [4:0]  RS1_D;
    logic [4:0]  RS2_D;
    logic [63:0] RD1_D;
    logic [63:0] RD2_D;
    logic        IssueValid;
    logic [4:0]  IssueRd;
    logic        Flush;
    logic        Stall;
    logic [5:0]  PendingCount;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [63:0] m_mem [32];
    bit          m_busy [32];
    int          m_pend;

    reg_file_scoreboard #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteData(WriteData),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .IssueValid(IssueValid), .IssueRd(IssueRd), .Flush(Flush),
        .Stall(Stall), .PendingCount(PendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value: x0 reads zero, a same-cycle write is visible,
    // otherwise the stored value.
    function automatic logic [63:0] m_read(input logic [4:0] rs);
        if (rs == 0) return 64'd0;
        if (WriteEn && WriteReg != 0 && WriteReg == rs) return WriteData;
        return m_mem[rs];
    endfunction

    function automatic bit m_src_busy(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        if (WriteEn && WriteReg != 0 && WriteReg == rs) return 1'b0;
        return m_busy[rs];
    endfunction

    task automatic drive(input bit r, input bit we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit iv, input logic [4:0] ird, input bit fl);
        @(negedge clk);
        rst = r; WriteEn = we; WriteReg = wr; WriteData = wd;
        RS1_D = rs1; RS2_D = rs2; IssueValid = iv; IssueRd = ird; Flush = fl;
        #1;
    endtask

    task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
        drive(0, 0, 0, 64'd0, rs1, rs2, 0, 0, 0);
    endtask

    task automatic check_comb();
        check_val("rd1", RD1_D, m_read(RS1_D));
        check_val("rd2", RD2_D, m_read(RS2_D));
        check_val("stall", {63'd0, Stall}, {63'd0, m_src_busy(RS1_D) || m_src_busy(RS2_D)});
    endtask

    // Advance one edge, apply the architectural rules to the model, then
    // compare the registered busy count.
    task automatic clock();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 64'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (WriteEn && WriteReg != 0) begin
                m_mem[WriteReg] = WriteData;
                m_busy[WriteReg] = 1'b0;
            end
            if (IssueValid && IssueRd != 0) m_busy[IssueRd] = 1'b1;
            if (Flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end
        end
        m_pend = 0;
        for (int i = 0; i < 32; i++) m_pend += int'(m_busy[i]);
        #1;
        check_val("pending", {58'd0, PendingCount}, 64'(m_pend));
    endtask

    initial begin
        rst = 1; WriteEn = 0; WriteReg = 0; WriteData = 0; RS1_D = 0; RS2_D = 0;
        IssueValid = 0; IssueRd = 0; Flush = 0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
        m_pend = 0;

        // Reset state
        drive(1, 0, 0, 64'd0, 0, 0, 0, 0, 0); clock();
        drive(1, 1, 4, 64'h55, 4, 0, 1, 4, 0); clock();
        idle(13, 22);
        check_val("rst_rd1", RD1_D, 64'd0);
        check_val("rst_rd2", RD2_D, 64'd0);
        check_val("rst_stall", {63'd0, Stall}, 64'd0);
        check_val("rst_pend", {58'd0, PendingCount}, 64'd0);
        check_comb(); clock();

        // Write then read, bypass and stored
        drive(0, 1, 5, 64'hDEAD_BEEF, 5, 0, 0, 0, 0);
        check_val("wr5_bypass", RD1_D, 64'hDEAD_BEEF);
        check_comb(); clock();
        idle(5, 5);
        check_val("wr5_stored", RD1_D, 64'hDEAD_BEEF);
        check_comb(); clock();

        // x0 protection
        drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
        check_val("x0_bypass_rd1", RD1_D, 64'd0);
        check_comb(); clock();
        check_val("x0_pend", {58'd0, PendingCount}, 64'd0);
        idle(0, 0);
        check_val("x0_rd1", RD1_D, 64'd0);
        check_val("x0_rd2", RD2_D, 64'd0);
        check_comb(); clock();

        // Hazard on x7
        drive(0, 0, 0, 64'd0, 0, 0, 1, 7, 0); check_comb(); clock();
        idle(0, 7);
        check_val("haz_stall", {63'd0, Stall}, 64'd1);
        check_val("haz_pend", {58'd0, PendingCount}, 64'd1);
        check_comb(); clock();
        drive(0, 1, 7, 64'h42, 0, 7, 0, 0, 0);
        check_val("haz_wb_stall", {63'd0, Stall}, 64'd0);
        check_val("haz_wb_rd2", RD2_D, 64'h42);
        check_comb(); clock();
        check_val("haz_wb_pend", {58'd0, PendingCount}, 64'd0);

        // Issue and write-back colliding on x3
        drive(0, 0, 0, 64'd0, 0, 0, 1, 3, 0); check_comb(); clock();
        drive(0, 1, 3, 64'h3333, 0, 0, 1, 3, 0); check_comb(); clock();
        check_val("coll_pend", {58'd0, PendingCount}, 64'd1);
        idle(3, 0);
        check_val("coll_stall", {63'd0, Stall}, 64'd1);
        check_val("coll_rd1", RD1_D, 64'h3333);
        check_comb(); clock();
        drive(0, 1, 3, 64'h3, 0, 0, 0, 0, 0); check_comb(); clock();

        // Flush overrides a same-cycle issue
        drive(0, 0, 0, 64'd0, 0, 0, 1, 2, 0); clock();
        drive(0, 0, 0, 64'd0, 0, 0, 1, 4, 0); clock();
        drive(0, 0, 0, 64'd0, 0, 0, 1, 6, 0); clock();
        check_val("fl_pend3", {58'd0, PendingCount}, 64'd3);
        drive(0, 0, 0, 64'd0, 9, 0, 1, 9, 1); check_comb(); clock();
        check_val("fl_pend0", {58'd0, PendingCount}, 64'd0);
        idle(9, 2);
        check_val("fl_stall", {63'd0, Stall}, 64'd0);
        check_comb(); clock();

        // Reset mid-run
        drive(0, 1, 10, 64'h1234, 0, 0, 0, 0, 0); clock();
        drive(0, 0, 0, 64'd0, 0, 0, 1, 11, 0); clock();
        idle(10, 11);
        check_val("pre_rst_rd1", RD1_D, 64'h1234);
        check_val("pre_rst_stall", {63'd0, Stall}, 64'd1);
        drive(1, 0, 0, 64'd0, 0, 0, 0, 0, 0); clock();
        idle(10, 11);
        check_val("mrst_rd1", RD1_D, 64'd0);
        check_val("mrst_stall", {63'd0, Stall}, 64'd0);
        check_val("mrst_pend", {58'd0, PendingCount}, 64'd0);
        check_comb(); clock();

        // Random traffic; small index range half the time to force collisions
        for (int n = 0; n < 1500; n++) begin
            bit          r, we, iv, fl;
            logic [4:0]  wr, rs1, rs2, ird;
            logic [63:0] wd;
            r   = ($urandom_range(0, 99) == 0);
            we  = $urandom_range(0, 1) == 1;
            iv  = $urandom_range(0, 1) == 1;
            fl  = ($urandom_range(0, 15) == 0);
            wr  = 5'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 7 : 31));
            ird = 5'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 7 : 31));
            rs1 = 5'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 7 : 31));
            rs2 = 5'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 7 : 31));
            wd  = {$urandom, $urandom};
            drive(r, we, wr, wd, rs1, rs2, iv, ird, fl);
            check_comb();
            clock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
